// File: rtl/pong_pkg.sv
// pong_pkg: VGA 640x480 timing constants, 12-bit coordinate types and rectangle hit test
package pong_pkg;
    localparam int COORD_W = 12;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x1;
        coord_t x2;
        coord_t y1;
        coord_t y2;
    } rect_t;

    function automatic logic rect_hit(input rect_t r, input logic [9:0] h, input logic [9:0] v);
        return (r.x1 <= coord_t'(h)) && (coord_t'(h) < r.x2) &&
               (r.y1 <= coord_t'(v)) && (coord_t'(v) < r.y2);
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate divider, h/v counters and registered sync, enable, position and frame strobe
module vga_timing import pong_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int HACT = H_ACTIVE,
    parameter int HFP = H_FP,
    parameter int HSYNC = H_SYNC,
    parameter int HBP = H_BP,
    parameter int VACT = V_ACTIVE,
    parameter int VFP = V_FP,
    parameter int VSYNC = V_SYNC,
    parameter int VBP = V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_stb,
    output logic       o_active,
    output logic       o_frame_end,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_ani_stb,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_de,
    output logic [9:0] o_h,
    output logic [9:0] o_v
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_END = 10'(HACT + HFP + HSYNC + HBP - 1);
    localparam logic [9:0] V_END = 10'(VACT + VFP + VSYNC + VBP - 1);
    localparam logic [9:0] HA = 10'(HACT);
    localparam logic [9:0] HS0 = 10'(HACT + HFP);
    localparam logic [9:0] HS1 = 10'(HACT + HFP + HSYNC);
    localparam logic [9:0] VA = 10'(VACT);
    localparam logic [9:0] VS0 = 10'(VACT + VFP);
    localparam logic [9:0] VS1 = 10'(VACT + VFP + VSYNC);

    logic [DW-1:0] div_q, div_d;
    logic [9:0] h_q, h_d, v_q, v_d, oh_q, oh_d, ov_q, ov_d;
    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ani_q, ani_d;

    always_comb begin
        o_stb = div_q == DIV_END;
        o_active = (h_q < HA) && (v_q < VA);
        o_frame_end = (h_q == H_END) && (v_q == V_END);
        div_d = o_stb ? '0 : div_q + 1'b1;
        h_d = o_stb ? (h_q == H_END ? '0 : h_q + 1'b1) : h_q;
        v_d = (o_stb && h_q == H_END) ? (v_q == V_END ? '0 : v_q + 1'b1) : v_q;
        hs_d = o_stb ? !(h_q >= HS0 && h_q < HS1) : hs_q;
        vs_d = o_stb ? !(v_q >= VS0 && v_q < VS1) : vs_q;
        de_d = o_stb ? o_active : de_q;
        oh_d = o_stb ? h_q : oh_q;
        ov_d = o_stb ? v_q : ov_q;
        ani_d = o_stb && h_q == '0 && v_q == VA;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
            h_q <= '0;
            v_q <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            de_q <= 1'b0;
            oh_q <= '0;
            ov_q <= '0;
            ani_q <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q <= h_d;
            v_q <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            oh_q <= oh_d;
            ov_q <= ov_d;
            ani_q <= ani_d;
        end
    end

    assign o_h_cnt = h_q;
    assign o_v_cnt = v_q;
    assign o_hs = hs_q;
    assign o_vs = vs_q;
    assign o_de = de_q;
    assign o_h = oh_q;
    assign o_v = ov_q;
    assign o_ani_stb = ani_q;
endmodule

// File: rtl/ball_raster.sv
// ball_raster: VGA raster drawing one filled rectangle latched once per frame during vertical blanking
module ball_raster import pong_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000,
    parameter int HACT = H_ACTIVE,
    parameter int HFP = H_FP,
    parameter int HSYNC = H_SYNC,
    parameter int HBP = H_BP,
    parameter int VACT = V_ACTIVE,
    parameter int VFP = V_FP,
    parameter int VSYNC = V_SYNC,
    parameter int VBP = V_BP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_x1,
    input  logic [11:0] i_x2,
    input  logic [11:0] i_y1,
    input  logic [11:0] i_y2,
    output logic        o_ani_stb,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_rgb,
    output logic [9:0]  o_h,
    output logic [9:0]  o_v
);
    logic stb, active, frame_end;
    logic [9:0] h_cnt, v_cnt;
    rect_t shadow_q, shadow_d;
    logic [11:0] rgb_q, rgb_d;

    vga_timing #(
        .CLK_DIV(CLK_DIV), .HACT(HACT), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VACT(VACT), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
    ) u_timing (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .o_stb(stb),
        .o_active(active),
        .o_frame_end(frame_end),
        .o_h_cnt(h_cnt),
        .o_v_cnt(v_cnt),
        .o_ani_stb(o_ani_stb),
        .o_hs(o_hs),
        .o_vs(o_vs),
        .o_de(o_de),
        .o_h(o_h),
        .o_v(o_v)
    );

    always_comb begin
        shadow_d = (stb && frame_end) ? {i_x1, i_x2, i_y1, i_y2} : shadow_q;
        rgb_d = stb ? (active ? (rect_hit(shadow_q, h_cnt, v_cnt) ? FG_RGB : BG_RGB) : 12'h000) : rgb_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q <= '0;
            rgb_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            rgb_q <= rgb_d;
        end
    end

    assign o_rgb = rgb_q;
endmodule
